// File: rtl/pipe_cla_adder.sv
// pipe_cla_adder: pipelined add/subtract built from 4-bit carry-lookahead
// groups joined by a second-level lookahead (no ripple between groups).
//
// Pipeline:
//   input register -> MID_STAGES (0..2) lookahead registers -> output register
//
// A single advance enable (en = !out_valid || out_ready) moves every stage
// together, so in_ready is just en. Each stage carries its own valid bit;
// bubbles travel with the data and are never squeezed out.
//
// Optional feature: define PIPE_CLA_SAT_EN to clamp sum to the signed
// max/min on overflow (ovf and cout still report the unclamped result).

module pipe_cla_adder #(
    parameter int WIDTH      = 16,
    parameter int MID_STAGES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NG = WIDTH / 4;

    if (WIDTH < 4 || (WIDTH % 4) != 0 || MID_STAGES < 0 || MID_STAGES > 2) begin : g_bad_params
        $error("pipe_cla_adder: WIDTH must be a multiple of 4 (>=4), MID_STAGES 0..2");
    end

    // Per-bit propagate/generate plus group-level P/G and the effective carry-in.
    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG-1:0]    gp;
        logic [NG-1:0]    gg;
        logic             c0;
    } pg_t;

    // Per-bit propagate/generate plus the carry into every group (gc[NG] = cout).
    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [NG:0]      gc;
    } cy_t;

    logic en;
    logic out_valid_q;

    assign en       = !out_valid_q || out_ready;
    assign in_ready = en;

    // ------------------------------------------------------------------
    // Input register stage
    // ------------------------------------------------------------------
    logic             in_vld_q, in_vld_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bx_q, bx_d;
    logic             c0_q, c0_d;

    // Next-state for the input stage: capture operands (b inverted for subtract) on accept.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        in_vld_d = en ? in_valid : in_vld_q;
        a_d      = a_q;
        bx_d     = bx_q;
        c0_d     = c0_q;
        if (en && in_valid) begin
            a_d  = a;
            bx_d = sub ? ~b : b;
            c0_d = cin ^ sub;
        end
    end

    // Input stage valid bit, cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) in_vld_q <= 1'b0;
        else        in_vld_q <= in_vld_d;
    end

    // Input stage operand registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are not reset; the valid bit beside them says whether they mean anything.
        a_q  <= a_d;
        bx_q <= bx_d;
        c0_q <= c0_d;
    end

    // ------------------------------------------------------------------
    // Level 1: bit and group propagate/generate
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] p_w;
    logic [WIDTH-1:0] g_w;
    pg_t              pg_c;

    assign p_w = a_q ^ bx_q;
    assign g_w = a_q & bx_q;

    // Group P is the AND of four propagates; group G is the 4-bit lookahead generate.
    always_comb begin
        pg_c    = '0;
        pg_c.p  = p_w;
        pg_c.g  = g_w;
        pg_c.c0 = c0_q;
        for (int i = 0; i < NG; i++) begin
            pg_c.gp[i] = &p_w[4*i +: 4];
            pg_c.gg[i] = g_w[4*i+3]
                       | (p_w[4*i+3] & g_w[4*i+2])
                       | (p_w[4*i+3] & p_w[4*i+2] & g_w[4*i+1])
                       | (p_w[4*i+3] & p_w[4*i+2] & p_w[4*i+1] & g_w[4*i]);
        end
    end

    pg_t  pg_s;
    logic pg_vld_s;

    if (MID_STAGES >= 1) begin : g_mid1
        logic m1_vld_q, m1_vld_d;
        pg_t  m1_pg_q, m1_pg_d;

        // Next-state for the first lookahead register: hold unless advancing a real beat.
        always_comb begin
            m1_vld_d = en ? in_vld_q : m1_vld_q;
            m1_pg_d  = m1_pg_q;
            if (en && in_vld_q) m1_pg_d = pg_c;
        end

        // First lookahead stage valid bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) m1_vld_q <= 1'b0;
            else        m1_vld_q <= m1_vld_d;
        end

        // First lookahead stage data.
        always_ff @(posedge clk) begin
            m1_pg_q <= m1_pg_d;
        end

        assign pg_s     = m1_pg_q;
        assign pg_vld_s = m1_vld_q;
    end else begin : g_no_mid1
        assign pg_s     = pg_c;
        assign pg_vld_s = in_vld_q;
    end

    // ------------------------------------------------------------------
    // Level 2: lookahead across groups
    // ------------------------------------------------------------------
    cy_t cy_c;

    // Each group carry is a flat sum of products of group G/P and c0, never a chain.
    always_comb begin
        logic term;
        logic carry;
        term       = 1'b0;
        carry      = 1'b0;
        cy_c       = '0;
        cy_c.p     = pg_s.p;
        cy_c.g     = pg_s.g;
        cy_c.gc[0] = pg_s.c0;
        for (int j = 1; j <= NG; j++) begin
            carry = 1'b0;
            for (int k = 0; k < j; k++) begin
                term = pg_s.gg[k];
                for (int m = k + 1; m < j; m++) term = term & pg_s.gp[m];
                carry = carry | term;
            end
            term = pg_s.c0;
            for (int m = 0; m < j; m++) term = term & pg_s.gp[m];
            carry      = carry | term;
            cy_c.gc[j] = carry;
        end
    end

    cy_t  cy_s;
    logic cy_vld_s;

    if (MID_STAGES >= 2) begin : g_mid2
        logic m2_vld_q, m2_vld_d;
        cy_t  m2_cy_q, m2_cy_d;

        // Next-state for the second lookahead register.
        always_comb begin
            m2_vld_d = en ? pg_vld_s : m2_vld_q;
            m2_cy_d  = m2_cy_q;
            if (en && pg_vld_s) m2_cy_d = cy_c;
        end

        // Second lookahead stage valid bit.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) m2_vld_q <= 1'b0;
            else        m2_vld_q <= m2_vld_d;
        end

        // Second lookahead stage data.
        always_ff @(posedge clk) begin
            m2_cy_q <= m2_cy_d;
        end

        assign cy_s     = m2_cy_q;
        assign cy_vld_s = m2_vld_q;
    end else begin : g_no_mid2
        assign cy_s     = cy_c;
        assign cy_vld_s = pg_vld_s;
    end

    // ------------------------------------------------------------------
    // Level 3: in-group carries, sum bits, flags
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] raw_c;
    logic [WIDTH-1:0] sum_c;
    logic             cout_c;
    logic             ovf_c;

    // In-group lookahead carries from the group carry-in, then sum = p ^ carry.
    always_comb begin
        logic term;
        logic carry;
        term  = 1'b0;
        carry = 1'b0;
        raw_c = '0;
        for (int i = 0; i < NG; i++) begin
            for (int bit_i = 0; bit_i < 4; bit_i++) begin
                carry = 1'b0;
                for (int k = 0; k < bit_i; k++) begin
                    term = cy_s.g[4*i+k];
                    for (int m = k + 1; m < bit_i; m++) term = term & cy_s.p[4*i+m];
                    carry = carry | term;
                end
                term = cy_s.gc[i];
                for (int m = 0; m < bit_i; m++) term = term & cy_s.p[4*i+m];
                carry = carry | term;
                raw_c[4*i+bit_i] = cy_s.p[4*i+bit_i] ^ carry;
            end
        end
    end

    // Flags: operand MSBs equal means p[msb] = 0, and then their shared sign is g[msb].
    always_comb begin
        cout_c = cy_s.gc[NG];
        ovf_c  = !cy_s.p[WIDTH-1] && (raw_c[WIDTH-1] != cy_s.g[WIDTH-1]);
`ifdef PIPE_CLA_SAT_EN
        sum_c = raw_c;
        if (ovf_c) begin
            sum_c = cy_s.g[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
`else
        sum_c = raw_c;
`endif
    end

    // ------------------------------------------------------------------
    // Output register stage
    // ------------------------------------------------------------------
    logic             out_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // Next-state for the output stage: results only change when a real beat advances in.
    always_comb begin
        out_valid_d = en ? cy_vld_s : out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        if (en && cy_vld_s) begin
            sum_d  = sum_c;
            cout_d = cout_c;
            ovf_d  = ovf_c;
        end
    end

    // Output stage: valid and visible result fields all clear on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
